cache_maint_engine: RTL and testbench
=====================================

# cache_maint_engine

Executes the cache maintenance commands issued on the cache command interface: `cmd`, `cmd_valid` and `cmd_ready`. It is the responder on that interface, and the cache control registers are the initiator.

- **clear:** write back every valid dirty line, then invalidate all lines.
- **wb:** write back every valid dirty line and mark it clean, leaving valid bits unchanged.

The block sits beside the cache core. It owns the tag/state array and data array ports while `busy` is high, and writes lines to memory through its own Avalon-style write master.

## Interface
Parameters:
- LINE_NUM, 64, number of cache lines (power of 2); IDX_W=log2(LINE_NUM)
- LINE_WORDS, 8, 32-bit words per line (power of 2); WRD_W=log2(LINE_WORDS); TAG_W=32-IDX_W-WRD_W-2

Ports:
- clk  in  1  clock; all logic on posedge
- rest  in  1  reset, synchronous, active-low
- cmd  in  3  command code: `cache_io_cmd_clear` or `cache_io_cmd_wb` from define.v
- cmd_valid  in  1  command request; held by the initiator until it sees cmd_ready
- cmd_ready  out  1  one-cycle completion pulse
- busy  out  1  engine owns the arrays; the cache core stalls
- tag_index  out  IDX_W  line index for tag read/write
- tag_rd  out  1  tag/state read strobe; tag_rd* valid exactly one cycle later
- tag_rdTag  in  TAG_W  stored tag
- tag_rdValid  in  1  stored valid bit
- tag_rdDirty  in  1  stored dirty bit
- tag_wr  out  1  tag/state write strobe; tag unchanged
- tag_wrValid  out  1  new valid bit
- tag_wrDirty  out  1  new dirty bit
- data_addr  out  IDX_W+WRD_W  {index, word}
- data_rd  out  1  data read strobe; data_rdData valid one cycle later
- data_rdData  in  32  read data
- m_address  out  32  memory write address {tag, index, word, 2'b00}
- m_byteEnable  out  4  constant 4'hF
- m_write  out  1  write request
- m_writeData  out  32  write data
- m_waitRequest  in  1  slave stall; m_write and m_address/m_writeData held while high

## Operation
All outputs are registered. Reset values: cmd_ready, busy, tag_rd, tag_wr, tag_wrValid, tag_wrDirty, data_rd and m_write are 0; tag_index, data_addr, m_address and m_writeData are 0.

Registers: state, idx (IDX_W bits), word (WRD_W bits), op (clear/wb), tag and dirty flag of the current line.

State machine:
- **IDLE**
  - busy=0.
  - If cmd_valid and cmd is a known code: latch op, set idx=0, go to TAG_RD.
  - If cmd_valid and cmd is unknown: go to DONE with no array activity.
- **TAG_RD:** busy=1; tag_rd=1, tag_index=idx. Go to TAG_CHK.
- **TAG_CHK:** latch tag_rdTag.
  - If tag_rdValid && tag_rdDirty: word=0, go to WB_RD.
  - Otherwise go to UPD.
- **WB_RD:** data_rd=1, data_addr={idx,word}. Go to WB_CAP.
- **WB_CAP:** m_writeData<=data_rdData, m_address<={tag,idx,word,2'b00}. Go to WB_WR.
- **WB_WR:** m_write=1, held until a cycle with m_waitRequest=0.
  - On that cycle, if word is the last word (all ones), go to UPD.
  - Otherwise word+1, go to WB_RD.
- **UPD:** tag_wr=1 for one cycle, tag_index=idx.
  - tag_wrDirty=0.
  - tag_wrValid=0 for clear; tag_wrValid=stored valid for wb.
  - If idx == LINE_NUM-1, go to DONE; otherwise idx+1 (no wrap needed), go to TAG_RD.
- **DONE:** cmd_ready=1 for exactly one cycle, busy=0. Go to IDLE.

Rules:
- cmd_valid is ignored outside IDLE.
- The initiator drops cmd_valid on the edge that samples cmd_ready, so IDLE never re-triggers on the same request.
- Every line receives exactly one tag read and one tag write per command, including invalid lines.
- Reset asserted mid-command aborts immediately: outputs return to reset values and no pending tag write or memory write completes. Partially processed arrays are left as they are.
- Dirty-bit write by the core cannot collide with the engine, because the core is stalled while busy=1.

## Timing
- busy rises the cycle after cmd_valid is sampled in IDLE.
- Clean or invalid line: 3 cycles (TAG_RD, TAG_CHK, UPD).
- Dirty line, no stalls: 3 + 3*LINE_WORDS cycles = 27 cycles at default parameters.
- Each cycle of m_waitRequest=1 adds one cycle.
- All-clean command at defaults: cmd_ready high in the 194th cycle after the sampling edge (192 line cycles + 1 busy-start + DONE).
- Unknown command: cmd_ready two cycles after sampling.
- Memory writes are in ascending word order within a line, and lines are processed in ascending index order.

## Test plan
- **All lines clean, op=wb:** no m_write; 64 tag_wr with tag_wrValid equal to the stored valid and dirty=0; a single cmd_ready pulse at cycle 194.
- **op=clear, line 3 valid+dirty, tag 21'h12, data words 0..7 = 0xA0..0xA7:** 8 writes at m_address 0x9060..0x907C with data 0xA0..0xA7; line 3 written valid=0, dirty=0; all other lines written valid=0.
- **op=wb, dirty lines 3 and 63, m_waitRequest high 4 cycles on word 2 of line 3:** m_address and m_writeData stable through the stall; 16 writes total; both lines end valid=1, dirty=0; completion 4 cycles later than with no stall.
- **Invalid but dirty line:** no writeback; tag_wr with dirty=0.
- **cmd=3'b111 (unknown):** no tag, data or memory activity; cmd_ready pulses 2 cycles later; a second cmd_valid during busy is ignored.
- **rest=0 during WB_WR of line 3 word 5:** next cycle m_write=0, busy=0, no tag_wr. After release, a new wb command restarts from idx 0 and rewrites line 3 from word 0.

Source files
------------

// File: rtl/cache_maint_engine.sv
// Cache maintenance engine: walks every line for clear/wb commands, writing dirty
// lines back through an Avalon-style write master while it owns the cache arrays.
module cache_maint_engine #(
  parameter int unsigned LINE_NUM   = 64,
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [2:0]  CMD_CLEAR  = 3'b001,
  parameter logic [2:0]  CMD_WB     = 3'b010,
  localparam int unsigned IDX_W = $clog2(LINE_NUM),
  localparam int unsigned WRD_W = $clog2(LINE_WORDS),
  localparam int unsigned TAG_W = 32 - IDX_W - WRD_W - 2
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic [2:0]             cmd,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic                   busy,
  output logic [IDX_W-1:0]       tag_index,
  output logic                   tag_rd,
  input  logic [TAG_W-1:0]       tag_rdTag,
  input  logic                   tag_rdValid,
  input  logic                   tag_rdDirty,
  output logic                   tag_wr,
  output logic                   tag_wrValid,
  output logic                   tag_wrDirty,
  output logic [IDX_W+WRD_W-1:0] data_addr,
  output logic                   data_rd,
  input  logic [31:0]            data_rdData,
  output logic [31:0]            m_address,
  output logic [3:0]             m_byteEnable,
  output logic                   m_write,
  output logic [31:0]            m_writeData,
  input  logic                   m_waitRequest
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_TAG_RD  = 4'd2;
  localparam logic [3:0] S_TAG_CHK = 4'd3;
  localparam logic [3:0] S_WB_RD   = 4'd4;
  localparam logic [3:0] S_WB_CAP  = 4'd5;
  localparam logic [3:0] S_WB_WR   = 4'd6;
  localparam logic [3:0] S_UPD     = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WRD_W-1:0] word_q, word_d;
  logic             op_wb_q, op_wb_d;
  logic             known_q, known_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             tag_rd_q, tag_rd_d;
  logic             tag_wr_q, tag_wr_d;
  logic             tag_wrValid_q, tag_wrValid_d;
  logic             data_rd_q, data_rd_d;
  logic             m_write_q, m_write_d;
  logic [31:0]      m_address_q, m_address_d;
  logic [31:0]      m_writeData_q, m_writeData_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    word_d        = word_q;
    op_wb_d       = op_wb_q;
    known_d       = known_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    m_address_d   = m_address_q;
    m_writeData_d = m_writeData_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          known_d = (cmd == CMD_CLEAR) || (cmd == CMD_WB);
          op_wb_d = (cmd == CMD_WB);
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START:   state_d = known_q ? S_TAG_RD : S_DONE;
      S_TAG_RD:  state_d = S_TAG_CHK;
      S_TAG_CHK: begin
        tag_d   = tag_rdTag;
        valid_d = tag_rdValid;
        if (tag_rdValid && tag_rdDirty) begin
          word_d  = '0;
          state_d = S_WB_RD;
        end else begin
          state_d = S_UPD;
        end
      end
      S_WB_RD:   state_d = S_WB_CAP;
      S_WB_CAP: begin
        m_writeData_d = data_rdData;
        m_address_d   = {tag_q, idx_q, word_q, 2'b00};
        state_d       = S_WB_WR;
      end
      S_WB_WR: begin
        if (!m_waitRequest) begin
          if (word_q == '1) begin
            state_d = S_UPD;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = S_WB_RD;
          end
        end
      end
      S_UPD: begin
        if (idx_q == '1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_TAG_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they are registered yet
    // line up with the state that owns them.
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE) &&
                    ((state_d != S_START) || known_d);
    tag_rd_d      = (state_d == S_TAG_RD);
    tag_wr_d      = (state_d == S_UPD);
    tag_wrValid_d = (state_d == S_UPD) && op_wb_d && valid_d;
    data_rd_d     = (state_d == S_WB_RD);
    m_write_d     = (state_d == S_WB_WR);
    cmd_ready_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      word_q        <= '0;
      op_wb_q       <= 1'b0;
      known_q       <= 1'b0;
      tag_q         <= '0;
      valid_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      tag_rd_q      <= 1'b0;
      tag_wr_q      <= 1'b0;
      tag_wrValid_q <= 1'b0;
      data_rd_q     <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writeData_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      op_wb_q       <= op_wb_d;
      known_q       <= known_d;
      tag_q         <= tag_d;
      valid_q       <= valid_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      tag_wrValid_q <= tag_wrValid_d;
      data_rd_q     <= data_rd_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writeData_q <= m_writeData_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign tag_index    = idx_q;
  assign tag_rd       = tag_rd_q;
  assign tag_wr       = tag_wr_q;
  assign tag_wrValid  = tag_wrValid_q;
  assign tag_wrDirty  = 1'b0;
  assign data_addr    = {idx_q, word_q};
  assign data_rd      = data_rd_q;
  assign m_address    = m_address_q;
  assign m_byteEnable = 4'hF;
  assign m_write      = m_write_q;
  assign m_writeData  = m_writeData_q;

endmodule

// File: tb/tb_cache_maint_engine.sv
// Directed bench for cache_maint_engine with behavioural tag/data arrays and a
// write slave that can stall on a chosen address.
module tb_cache_maint_engine;

  localparam logic [2:0] CMD_CLEAR = 3'b001;
  localparam logic [2:0] CMD_WB    = 3'b010;
  localparam logic [2:0] CMD_BAD   = 3'b111;

  logic        clk = 1'b0;
  logic        rest;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready, busy;
  logic [5:0]  tag_index;
  logic        tag_rd;
  logic [20:0] tag_rdTag;
  logic        tag_rdValid, tag_rdDirty;
  logic        tag_wr, tag_wrValid, tag_wrDirty;
  logic [8:0]  data_addr;
  logic        data_rd;
  logic [31:0] data_rdData;
  logic [31:0] m_address;
  logic [3:0]  m_byteEnable;
  logic        m_write;
  logic [31:0] m_writeData;
  logic        m_waitRequest = 1'b0;

  cache_maint_engine #(.LINE_NUM(64), .LINE_WORDS(8), .CMD_CLEAR(CMD_CLEAR), .CMD_WB(CMD_WB)) dut (
    .clk(clk), .rest(rest), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy),
    .tag_index(tag_index), .tag_rd(tag_rd), .tag_rdTag(tag_rdTag), .tag_rdValid(tag_rdValid),
    .tag_rdDirty(tag_rdDirty), .tag_wr(tag_wr), .tag_wrValid(tag_wrValid), .tag_wrDirty(tag_wrDirty),
    .data_addr(data_addr), .data_rd(data_rd), .data_rdData(data_rdData), .m_address(m_address),
    .m_byteEnable(m_byteEnable), .m_write(m_write), .m_writeData(m_writeData),
    .m_waitRequest(m_waitRequest)
  );

  always #5 clk = ~clk;

  logic [20:0] tag_mem [64];
  logic        v_mem   [64];
  logic        d_mem   [64];
  logic [31:0] dat_mem [512];
  logic [31:0] wa [64];
  logic [31:0] wd [64];

  int total = 0, bad = 0;
  int cyc = 0, n_wr = 0, n_tag_rd = 0, n_tag_wr = 0, n_tag_wr_bad = 0;
  int n_data_rd = 0, n_ready = 0, ready_at = -1;
  int cur_wb = 0, stall_left = 0, stall_seen = 0;
  logic [31:0] stall_addr = '0, snap_d = '0;
  int lat, t0, cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Array and slave model; array read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (tag_rd) begin
      tag_rdTag   <= tag_mem[tag_index];
      tag_rdValid <= v_mem[tag_index];
      tag_rdDirty <= d_mem[tag_index];
      n_tag_rd++;
    end
    if (tag_wr) begin
      n_tag_wr++;
      if (tag_wrDirty !== 1'b0 || tag_wrValid !== ((cur_wb != 0) ? v_mem[tag_index] : 1'b0))
        n_tag_wr_bad++;
      v_mem[tag_index] = tag_wrValid;
      d_mem[tag_index] = tag_wrDirty;
    end
    if (data_rd) begin
      data_rdData <= dat_mem[data_addr];
      n_data_rd++;
    end
    if (m_write && !m_waitRequest && n_wr < 64) begin
      wa[n_wr] = m_address;
      wd[n_wr] = m_writeData;
      n_wr++;
    end
    if (cmd_ready) begin
      n_ready++;
      ready_at = cyc;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (stall_left > 0 && m_write && m_address == stall_addr) begin
      m_waitRequest = 1'b1;
      stall_left--;
      stall_seen++;
      if (stall_seen == 1) snap_d = m_writeData;
      else chk("stall_data_hold", m_writeData, snap_d);
    end else begin
      m_waitRequest = 1'b0;
    end
  end

  task automatic clear_log();
    n_wr = 0; n_tag_rd = 0; n_tag_wr = 0; n_tag_wr_bad = 0;
    n_data_rd = 0; n_ready = 0; ready_at = -1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++) begin
      tag_mem[i] = 21'(i * 3 + 1);
      v_mem[i]   = 1'b1;
      d_mem[i]   = 1'b0;
    end
    for (int j = 0; j < 512; j++) dat_mem[j] = 32'h5500_0000 ^ 32'(j);
  endtask

  task automatic set_dirty(input int idx, input logic [20:0] tg, input logic [31:0] base);
    tag_mem[idx] = tg;
    v_mem[idx]   = 1'b1;
    d_mem[idx]   = 1'b1;
    for (int w = 0; w < 8; w++) dat_mem[idx * 8 + w] = base + 32'(w);
  endtask

  function automatic int count_valid();
    int s = 0;
    for (int i = 0; i < 64; i++) if (v_mem[i]) s++;
    return s;
  endfunction

  task automatic run_cmd(input logic [2:0] c, output int l);
    int n = 0;
    @(negedge clk);
    cmd = c; cmd_valid = 1'b1; t0 = cyc;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    chk("ready_timeout", 32'(n < 2000), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    l = ready_at - t0;
  endtask

  initial begin
    rest = 1'b0; cmd = '0; cmd_valid = 1'b0;
    init_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_mwrite", 32'(m_write), 32'd0);
    chk("rst_tagwr", 32'(tag_wr), 32'd0);
    chk("rst_maddr", m_address, 32'd0);
    chk("rst_byteen", 32'(m_byteEnable), 32'hF);
    rest = 1'b1;
    @(negedge clk);

    // wb over clean lines, alternate lines invalid
    init_mem();
    for (int i = 0; i < 64; i++) v_mem[i] = (i % 2 == 1);
    clear_log(); cur_wb = 1;
    run_cmd(CMD_WB, lat);
    chk("clean_latency", 32'(lat), 32'd194);
    chk("clean_nwr", 32'(n_wr), 32'd0);
    chk("clean_ntagrd", 32'(n_tag_rd), 32'd64);
    chk("clean_ntagwr", 32'(n_tag_wr), 32'd64);
    chk("clean_tagwr_bad", 32'(n_tag_wr_bad), 32'd0);
    chk("clean_ndatard", 32'(n_data_rd), 32'd0);
    chk("clean_nready", 32'(n_ready), 32'd1);
    chk("clean_valid_kept", 32'(count_valid()), 32'd32);

    // clear with line 3 dirty
    init_mem();
    set_dirty(3, 21'h12, 32'hA0);
    clear_log(); cur_wb = 0;
    run_cmd(CMD_CLEAR, lat);
    chk("clr_latency", 32'(lat), 32'd218);
    chk("clr_nwr", 32'(n_wr), 32'd8);
    for (int w = 0; w < 8; w++) begin
      chk("clr_addr", wa[w], 32'h9060 + 32'(w * 4));
      chk("clr_data", wd[w], 32'hA0 + 32'(w));
    end
    chk("clr_tagwr_bad", 32'(n_tag_wr_bad), 32'd0);
    chk("clr_valid_cnt", 32'(count_valid()), 32'd0);
    chk("clr_line3_dirty", 32'(d_mem[3]), 32'd0);

    // wb with lines 3 and 63 dirty, 4-cycle stall on line 3 word 2
    init_mem();
    set_dirty(3, 21'h12, 32'hA0);
    set_dirty(63, 21'h155, 32'hB0);
    stall_addr = 32'h9068; stall_left = 4; stall_seen = 0;
    clear_log(); cur_wb = 1;
    run_cmd(CMD_WB, lat);
    chk("stall_latency", 32'(lat), 32'd246);
    chk("stall_cycles", 32'(stall_seen), 32'd4);
    chk("stall_nwr", 32'(n_wr), 32'd16);
    chk("stall_w2_addr", wa[2], 32'h9068);
    chk("stall_w2_data", wd[2], 32'hA2);
    chk("l63_first_addr", wa[8], 32'h000A_AFE0);
    chk("l63_last_addr", wa[15], 32'h000A_AFFC);
    chk("l63_last_data", wd[15], 32'hB7);
    chk("l3_state", {30'd0, v_mem[3], d_mem[3]}, 32'd2);
    chk("l63_state", {30'd0, v_mem[63], d_mem[63]}, 32'd2);
    chk("stall_tagwr_bad", 32'(n_tag_wr_bad), 32'd0);

    // invalid but dirty line is not written back
    init_mem();
    v_mem[5] = 1'b0; d_mem[5] = 1'b1;
    clear_log(); cur_wb = 1;
    run_cmd(CMD_WB, lat);
    chk("inv_dirty_nwr", 32'(n_wr), 32'd0);
    chk("inv_dirty_line5", {30'd0, v_mem[5], d_mem[5]}, 32'd0);
    chk("inv_dirty_tagwr_bad", 32'(n_tag_wr_bad), 32'd0);

    // unknown command
    init_mem();
    clear_log();
    run_cmd(CMD_BAD, lat);
    chk("bad_latency", 32'(lat), 32'd2);
    chk("bad_activity", 32'(n_tag_rd + n_tag_wr + n_data_rd + n_wr), 32'd0);

    // new request while busy is ignored
    init_mem();
    clear_log(); cur_wb = 1;
    @(negedge clk);
    cmd = CMD_WB; cmd_valid = 1'b1; t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd1);
    cmd = CMD_CLEAR; cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0;
    while (!cmd_ready && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("ign_timeout", 32'(cnt < 2000), 32'd1);
    repeat (6) @(negedge clk);
    chk("ign_latency", 32'(ready_at - t0), 32'd194);
    chk("ign_nready", 32'(n_ready), 32'd1);
    chk("ign_valid_kept", 32'(count_valid()), 32'd64);

    // reset while word 5 of line 3 is stalled on the bus
    init_mem();
    set_dirty(3, 21'h12, 32'hA0);
    stall_addr = 32'h9074; stall_left = 1000; stall_seen = 0;
    clear_log(); cur_wb = 1;
    @(negedge clk);
    cmd = CMD_WB; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0;
    while (stall_seen < 2 && cnt < 500) begin @(negedge clk); cnt++; end
    chk("abort_reach_timeout", 32'(cnt < 500), 32'd1);
    rest = 1'b0;
    @(negedge clk);
    chk("abort_mwrite", 32'(m_write), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tagwr", 32'(tag_wr), 32'd0);
    chk("abort_maddr", m_address, 32'd0);
    chk("abort_nwr", 32'(n_wr), 32'd5);
    chk("abort_line3_dirty", 32'(d_mem[3]), 32'd1);
    stall_left = 0;
    rest = 1'b1;
    @(negedge clk);
    clear_log();
    run_cmd(CMD_WB, lat);
    chk("restart_latency", 32'(lat), 32'd218);
    chk("restart_nwr", 32'(n_wr), 32'd8);
    chk("restart_addr0", wa[0], 32'h9060);
    chk("restart_data0", wd[0], 32'hA0);
    chk("restart_data5", wd[5], 32'hA5);
    chk("restart_line3", {30'd0, v_mem[3], d_mem[3]}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
